// File: rtl/td4_prog_mem_pkg.sv
// -----------------------------------------------------------------------------
// td4_prog_mem_pkg
// Shared definitions for the TD4 serial-loadable program memory:
//   - memory geometry (depth 16, 8-bit words, 4-bit address)
//   - controller state encoding (RUN / LOAD / RELEASE)
//   - debug bundle exposing controller and deserializer state
// -----------------------------------------------------------------------------
package td4_prog_mem_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int WORD_W    = 8;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int BCNT_W    = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Observation bundle for checkers: controller state plus deserializer state.
    typedef struct packed {
        state_e              state;
        logic [BCNT_W-1:0]   bit_cnt;
        logic [WORD_W-1:0]   shift;
    } dbg_t;

endpackage

// File: rtl/td4_sipo_8bit.sv
// -----------------------------------------------------------------------------
// td4_sipo_8bit
// Serial-in parallel-out deserializer: 8-bit shift register (MSB first, new
// bit enters at the LSB) plus a 3-bit count of accepted bits.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr_i          synchronous clear of shift register and bit counter
//                  (takes priority over shift_en_i for the stored state)
//   shift_en_i     accept sdi_i on this edge
//   sdi_i          serial data bit
//   byte_o         completed byte {shift[6:0], sdi_i}, valid when byte_ready_o
//   byte_ready_o   high in the cycle whose edge accepts the 8th bit
//   shift_o        current shift register contents
//   bit_cnt_o      number of bits accepted toward the current byte
// -----------------------------------------------------------------------------
module td4_sipo_8bit
    import td4_prog_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic              sdi_i,
    output logic [WORD_W-1:0] byte_o,
    output logic              byte_ready_o,
    output logic [WORD_W-1:0] shift_o,
    output logic [BCNT_W-1:0] bit_cnt_o
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_en_i) begin
            shift_d = {shift_q[WORD_W-2:0], sdi_i};
            // Counter wraps 7 -> 0 on the 8th bit, ready for the next byte.
            cnt_d   = cnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The completed byte includes the bit being accepted this cycle, so the
    // consumer can write it on the same edge that accepts the 8th bit.
    assign byte_o       = {shift_q[WORD_W-2:0], sdi_i};
    assign byte_ready_o = shift_en_i && (cnt_q == BCNT_W'(WORD_W - 1));
    assign shift_o      = shift_q;
    assign bit_cnt_o    = cnt_q;

endmodule

// File: rtl/td4_prog_mem.sv
// -----------------------------------------------------------------------------
// td4_prog_mem
// 16 x 8 program memory for a TD4-style CPU with a serial loader. The CPU
// reads combinationally at any time; a load session streams bytes MSB first
// and writes them sequentially from index 0 while holding the CPU in reset.
//
// Parameters:
//   RELEASE_CYC   cycles cpu_hold stays high after a load ends (must be >= 1)
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   addr          CPU fetch address
//   data          mem[addr], combinational
//   ld_en         load session request (level)
//   bit_vld       one-cycle strobe qualifying sdi
//   sdi           serial program bit, MSB first
//   cpu_hold      high in LOAD and RELEASE (CPU reset)
//   ld_busy       high in LOAD
//   ld_done       one-cycle pulse after the 16th byte has been written
//   wptr          index of the next byte to be written
//   dbg_o         controller state, bit count and shift register
//
// Handshake: sdi is consumed on every rising edge where bit_vld is high and
// the controller is in LOAD; there is no back-pressure, bits strobed in any
// other state are dropped.
// -----------------------------------------------------------------------------
module td4_prog_mem
    import td4_prog_mem_pkg::*;
#(
    parameter int RELEASE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data,
    input  logic              ld_en,
    input  logic              bit_vld,
    input  logic              sdi,
    output logic              cpu_hold,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W-1:0] wptr,
    output dbg_t              dbg_o
);

    localparam int                RC_W     = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [RC_W-1:0]   REL_LAST = RC_W'(RELEASE_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [RC_W-1:0]   rel_cnt_q;
    logic              cpu_hold_q;
    logic              ld_busy_q;
    logic              ld_done_q;
    logic [WORD_W-1:0] mem_q [MEM_DEPTH];

    logic              shift_en;
    logic              sipo_clr;
    logic              byte_wr;
    logic              last_byte;
    logic              load_end;
    logic [WORD_W-1:0] sipo_byte;
    logic [WORD_W-1:0] sipo_shift;
    logic [BCNT_W-1:0] sipo_cnt;

    // Deserializer
    td4_sipo_8bit u_sipo (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (sipo_clr),
        .shift_en_i   (shift_en),
        .sdi_i        (sdi),
        .byte_o       (sipo_byte),
        .byte_ready_o (byte_wr),
        .shift_o      (sipo_shift),
        .bit_cnt_o    (sipo_cnt)
    );

    // Event decode. A byte completing on the same edge that ld_en is seen low
    // is still written; the abort only redirects the next state.
    always_comb begin
        shift_en  = (state_q == ST_LOAD) && bit_vld;
        last_byte = byte_wr && (wptr_q == LAST_IDX);
        load_end  = (state_q == ST_LOAD) && (last_byte || !ld_en);
        // Clear on entry to LOAD, and on exit so a partial byte never lingers.
        sipo_clr  = ((state_q == ST_RUN) && ld_en) || load_end;
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wptr_q     <= '0;
            rel_cnt_q  <= '0;
            cpu_hold_q <= 1'b0;
            ld_busy_q  <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (ld_en) begin
                        state_q    <= ST_LOAD;
                        wptr_q     <= '0;
                        cpu_hold_q <= 1'b1;
                        ld_busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (byte_wr) begin
                        wptr_q <= wptr_q + ADDR_W'(1);  // wraps 15 -> 0
                    end
                    if (load_end) begin
                        state_q   <= ST_RELEASE;
                        ld_busy_q <= 1'b0;
                        rel_cnt_q <= '0;
                        ld_done_q <= last_byte;
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt_q == REL_LAST) begin
                        state_q    <= ST_RUN;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        rel_cnt_q <= rel_cnt_q + RC_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    cpu_hold_q <= 1'b0;
                    ld_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Program array: reset to NOP, written only by the deserializer in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (byte_wr) begin
            mem_q[wptr_q] <= sipo_byte;
        end
    end

    assign data     = mem_q[addr];
    assign cpu_hold = cpu_hold_q;
    assign ld_busy  = ld_busy_q;
    assign ld_done  = ld_done_q;
    assign wptr     = wptr_q;

    always_comb begin
        dbg_o         = '0;
        dbg_o.state   = state_q;
        dbg_o.bit_cnt = sipo_cnt;
        dbg_o.shift   = sipo_shift;
    end

endmodule

// File: tb/tb_td4_prog_mem.sv
module tb_td4_prog_mem;
  import td4_prog_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [3:0] addr;
  logic [7:0] data;
  logic ld_en, bit_vld, sdi;
  logic cpu_hold, ld_busy, ld_done;
  logic [3:0] wptr;
  dbg_t dbg;

  always #5 clk = ~clk;

  td4_prog_mem #(.RELEASE_CYC(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data),
    .ld_en(ld_en), .bit_vld(bit_vld), .sdi(sdi),
    .cpu_hold(cpu_hold), .ld_busy(ld_busy), .ld_done(ld_done),
    .wptr(wptr), .dbg_o(dbg)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  logic [7:0] exp_q[$];
  logic [7:0] model_mem [16];
  rd_vec_t    rd_tbl [16];
  logic [7:0] load_tbl [16];
  logic [3:0] exp_wptr;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  // ld_done pulse counter, sampled away from the active edge
  always @(negedge clk) if (ld_done === 1'b1) done_cnt = done_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one strobed bit, followed by gap idle cycles
  task automatic send_bit(input logic b, input int gap);
    bit_vld = 1'b1;
    sdi = b;
    step();
    bit_vld = 1'b0;
    repeat (gap) step();
  endtask

  // MSB first; returns one tick after the edge that accepted the 8th bit
  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 1; i--) send_bit(b[i], gap);
    send_bit(b[0], 0);
    model_mem[exp_wptr] = b;
    exp_wptr = exp_wptr + 4'd1;
  endtask

  task automatic verify_mem(input string tag);
    for (int i = 0; i < 16; i++) exp_q.push_back(model_mem[i]);
    for (int i = 0; i < 16; i++) begin
      rd_tbl[i].addr = 4'(i);
      rd_tbl[i].exp  = exp_q.pop_front();
    end
    for (int i = 0; i < 16; i++) begin
      addr = rd_tbl[i].addr;
      #1;
      check($sformatf("%s_mem%0d", tag, i), 32'(data), 32'(rd_tbl[i].exp));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    load_tbl = '{8'hB1, 8'hF0, 8'h23, 8'h4C, 8'h95, 8'h6E, 8'h07, 8'hD8,
                 8'h3A, 8'hC2, 8'h5F, 8'h81, 8'h1E, 8'hA4, 8'h79, 8'hE6};
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    exp_wptr = 4'd0;

    rst = 1'b1; addr = 4'd0; ld_en = 1'b0; bit_vld = 1'b0; sdi = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // reset state and NOP sweep
    check("rst_state", 32'(dbg.state), 32'(ST_RUN));
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_ld_busy", 32'(ld_busy), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_wptr", 32'(wptr), 32'd0);
    verify_mem("rst_sweep");

    // full load, bit_vld every 3rd cycle
    ld_en = 1'b1;
    step();
    check("ld1_state", 32'(dbg.state), 32'(ST_LOAD));
    check("ld1_cpu_hold_first", 32'(cpu_hold), 32'd1);
    check("ld1_busy", 32'(ld_busy), 32'd1);
    check("ld1_wptr0", 32'(wptr), 32'd0);
    done_base = done_cnt;
    for (int k = 0; k < 16; k++) begin
      send_byte(load_tbl[k], 2);
      if (k == 0) check("ld1_wptr_after_b0", 32'(wptr), 32'd1);
      if (k == 15) begin
        check("ld1_done_pulse", 32'(ld_done), 32'd1);
        check("ld1_release", 32'(dbg.state), 32'(ST_RELEASE));
        check("ld1_wptr_wrap", 32'(wptr), 32'd0);
        check("ld1_busy_rel", 32'(ld_busy), 32'd0);
        check("ld1_hold_rel", 32'(cpu_hold), 32'd1);
      end else begin
        check($sformatf("ld1_nodone%0d", k), 32'(ld_done), 32'd0);
        repeat (2) step();
      end
    end
    ld_en = 1'b0;
    step();
    check("ld1_done_one_cycle", 32'(ld_done), 32'd0);
    check("ld1_hold_rel2", 32'(cpu_hold), 32'd1);
    step();
    check("ld1_run", 32'(dbg.state), 32'(ST_RUN));
    check("ld1_hold_off", 32'(cpu_hold), 32'd0);
    check("ld1_done_count", 32'(done_cnt - done_base), 32'd1);
    verify_mem("ld1");

    // abort after 5 bytes plus 3 bits
    done_base = done_cnt;
    exp_wptr = 4'd0;
    ld_en = 1'b1;
    step();
    check("ab_state", 32'(dbg.state), 32'(ST_LOAD));
    check("ab_shift_clear", 32'(dbg.shift), 32'd0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h0F, 0);
    send_byte(8'hF1, 0);
    send_byte(8'h66, 0);
    send_bit(1'b1, 1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    check("ab_bitcnt", 32'(dbg.bit_cnt), 32'd3);
    check("ab_wptr_load", 32'(wptr), 32'd5);
    ld_en = 1'b0;
    step();
    check("ab_release", 32'(dbg.state), 32'(ST_RELEASE));
    check("ab_no_done", 32'(ld_done), 32'd0);
    // strobes during RELEASE must be ignored
    bit_vld = 1'b1; sdi = 1'b1;
    step();
    bit_vld = 1'b0;
    check("ab_release2", 32'(dbg.state), 32'(ST_RELEASE));
    check("ab_wptr_rel", 32'(wptr), 32'd5);
    step();
    check("ab_run", 32'(dbg.state), 32'(ST_RUN));
    check("ab_done_count", 32'(done_cnt - done_base), 32'd0);
    verify_mem("abort");

    // ld_en falls on the same edge as the 8th bit of byte 2
    done_base = done_cnt;
    exp_wptr = 4'd0;
    ld_en = 1'b1;
    step();
    send_byte(8'h11, 1);
    step();
    send_byte(8'h22, 1);
    step();
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h3C >> i), 1);
    bit_vld = 1'b1; sdi = 1'b0; ld_en = 1'b0;
    step();
    bit_vld = 1'b0;
    model_mem[2] = 8'h3C;
    check("eq_release", 32'(dbg.state), 32'(ST_RELEASE));
    check("eq_wptr", 32'(wptr), 32'd3);
    check("eq_no_done", 32'(ld_done), 32'd0);
    addr = 4'd2;
    #1;
    check("eq_mem2_rel", 32'(data), 32'h3C);
    step(); step();
    check("eq_run", 32'(dbg.state), 32'(ST_RUN));
    check("eq_done_count", 32'(done_cnt - done_base), 32'd0);
    verify_mem("same_edge");

    // ld_en held high through a full load, then reset mid second session
    done_base = done_cnt;
    exp_wptr = 4'd0;
    ld_en = 1'b1;
    step();
    for (int k = 0; k < 16; k++) send_byte(load_tbl[15 - k], 0);
    check("hh_done", 32'(ld_done), 32'd1);
    check("hh_release", 32'(dbg.state), 32'(ST_RELEASE));
    step();
    check("hh_release2", 32'(dbg.state), 32'(ST_RELEASE));
    step();
    check("hh_run_gap", 32'(dbg.state), 32'(ST_RUN));
    check("hh_hold_gap", 32'(cpu_hold), 32'd0);
    step();
    check("hh_load2", 32'(dbg.state), 32'(ST_LOAD));
    check("hh_wptr2", 32'(wptr), 32'd0);
    check("hh_hold2", 32'(cpu_hold), 32'd1);
    check("hh_done_count", 32'(done_cnt - done_base), 32'd1);
    addr = 4'd0;
    for (int k = 0; k < 7; k++) send_byte(8'hC0 | 8'(k), 0);
    check("rm_wptr7", 32'(wptr), 32'd7);
    check("rm_mem0_pre", 32'(data), 32'hC0);
    #2;
    rst = 1'b1;
    #1;
    check("rm_async_state", 32'(dbg.state), 32'(ST_RUN));
    check("rm_async_hold", 32'(cpu_hold), 32'd0);
    check("rm_async_mem0", 32'(data), 32'h00);
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    exp_wptr = 4'd0;
    step();
    rst = 1'b0; ld_en = 1'b0;
    step();
    check("rm_state", 32'(dbg.state), 32'(ST_RUN));
    check("rm_wptr", 32'(wptr), 32'd0);
    check("rm_busy", 32'(ld_busy), 32'd0);
    check("rm_done_count", 32'(done_cnt - done_base), 32'd1);
    verify_mem("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/td4_prog_mem.md
TD4_PROG_MEM -- requirements
Module: td4_prog_mem

Interface
REQ-001 Parameter RELEASE_CYC, default 2: cycles cpu_hold stays high after a load ends.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 addr  input  4  CPU fetch address (program counter).
REQ-005 data  output  8  instruction byte at addr, op in [7:4], immediate in [3:0].
REQ-006 ld_en  input  1  load request; high = serial load session active.
REQ-007 bit_vld  input  1  one-cycle strobe qualifying sdi.
REQ-008 sdi  input  1  serial program bit, MSB first.
REQ-009 cpu_hold  output  1  active-high hold, used as the CPU's reset during loading.
REQ-010 ld_busy  output  1  high in LOAD state.
REQ-011 ld_done  output  1  one-cycle pulse when a session ends with all 16 bytes written.
REQ-012 wptr  output  4  index of the next byte to be written.

Function
REQ-013 Storage: 16 x 8-bit array; data = mem[addr] combinationally, zero added latency, in every state.
REQ-014 FSM states: RUN, LOAD, RELEASE.
REQ-015 RUN: cpu_hold=0; ld_en=1 -> LOAD next cycle; shift register, bit counter and wptr cleared on entry.
REQ-016 LOAD: cpu_hold=1, ld_busy=1; each cycle with bit_vld=1 shifts sdi into the LSB of an 8-bit shift register; bit_vld=0 cycles change nothing.
REQ-017 On the 8th accepted bit, {shift[6:0],sdi} is written to mem[wptr] in that same edge, the bit counter returns to 0 and wptr increments.
REQ-018 Write of byte index 15: ld_done pulses on the following cycle, wptr wraps to 0, FSM -> RELEASE regardless of ld_en.
REQ-019 ld_en dropping in LOAD (abort): partial byte discarded, entries not yet rewritten keep prior contents, no ld_done, FSM -> RELEASE.
REQ-020 ld_en falling on the same edge as an 8th bit: the byte is written first, then the abort applies.
REQ-021 RELEASE: cpu_hold=1, ld_busy=0, bit_vld ignored; after RELEASE_CYC cycles -> RUN.
REQ-022 ld_en still high at the end of RELEASE -> RUN for one cycle, then LOAD again; a new session requires ld_en to be seen high in RUN.
REQ-023 Writes occur only in LOAD; in RUN and RELEASE the array is read-only.

Reset
REQ-024 rst=1 asynchronously forces: FSM=RUN, all 16 entries=8'h00 (NOP), shift register=0, bit counter=0, wptr=0, cpu_hold=0, ld_busy=0, ld_done=0.
REQ-025 rst asserted mid-LOAD: session lost, array zeroed, no ld_done; after release, FSM in RUN.

Structure
REQ-026 Shared package holds the state encoding (RUN/LOAD/RELEASE), the memory depth (16) and the word width (8).
REQ-027 One sub-module, td4_sipo_8bit: 8-bit shift register plus 3-bit bit counter with a byte_ready output; FSM and array stay in the top module.

Verification
REQ-028 After reset, sweep addr 0..15 -> data=8'h00 at every address; cpu_hold=0.
REQ-029 Load 16 bytes 8'hB1,8'hF0,... with bit_vld every 3rd cycle -> ld_done pulses once after byte 15; cpu_hold high from the first LOAD cycle through RELEASE_CYC cycles after; data at addr 0 = 8'hB1, addr 1 = 8'hF0.
REQ-030 Abort: load 5 bytes plus 3 bits of the 6th, drop ld_en -> mem[0..4] new, mem[5..15] unchanged, wptr=5 before the return to RUN, no ld_done.
REQ-031 ld_en falls on the same edge as the 8th bit of byte 2 (8'h3C) -> mem[2]=8'h3C, FSM -> RELEASE.
REQ-032 rst pulsed mid-LOAD after 7 bytes -> all entries read 8'h00, cpu_hold=0, FSM in RUN.
REQ-033 ld_en held high through a full load -> RUN for exactly one cycle between sessions, then a second session starts with wptr=0.
